// File: rtl/sao_deci_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : sao_deci_pkg                                               |
// | Description : Shared widths, limits and group indices for the SAO        |
// |               decision offset estimator.                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package sao_deci_pkg;

   localparam int OFF_LEN     = 4;
   localparam int DIST_LEN    = 21;
   localparam int SAO_OFF_MAX = 7;

   // Worst possible cost, reported for a merge group with no candidate.
   localparam logic signed [DIST_LEN-1:0] DIST_MAX = {1'b0, {(DIST_LEN-1){1'b1}}};

   typedef enum logic [2:0] {
      GRP_EO0   = 3'd0,
      GRP_EO1   = 3'd1,
      GRP_EO2   = 3'd2,
      GRP_EO3   = 3'd3,
      GRP_BO_LO = 3'd4,
      GRP_BO_HI = 3'd5,
      GRP_MRG_L = 3'd6,
      GRP_MRG_U = 3'd7
   } sao_grp_e;

   // Merge groups take their offsets from a neighbour instead of estimating.
   function automatic logic is_merge_grp(input logic [2:0] grp);
      return (grp >= GRP_MRG_L);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sao_off_mag.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sao_off_mag                                                |
// | Description : Combinational offset magnitude from (|sum|, num), clipped  |
// |               to SAO_OFF_MAX; zero when num is zero.                     |
// | Config      : SAO_OFFSET_ROUND_EN defined   -> largest k with            |
// |                                               2|sum| >= (2k-1)*num       |
// |               SAO_OFFSET_ROUND_EN undefined -> largest k with            |
// |                                               |sum| >= k*num             |
// | Ports       : i_num     category pixel count                             |
// |               i_abs_sum magnitude of the category difference sum         |
// |               o_mag     3-bit offset magnitude                           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sao_off_mag
   import sao_deci_pkg::*;
#(
   parameter int NUM_W = 10,
   parameter int SUM_W = 14
)(
   input  logic [NUM_W-1:0] i_num,
   input  logic [SUM_W-1:0] i_abs_sum,
   output logic [2:0]       o_mag
);

   // Wide enough for 13*num and 2*|sum| without overflow.
   localparam int c_CMP_W = ((NUM_W > SUM_W) ? NUM_W : SUM_W) + 5;

   logic [c_CMP_W-1:0] w_lhs;
   logic [c_CMP_W-1:0] w_num;
   logic [c_CMP_W-1:0] w_thr;

   // Thresholds grow with k, so the last passing k is the largest one.
   always_comb begin
      w_num = c_CMP_W'(i_num);
`ifdef SAO_OFFSET_ROUND_EN
      w_lhs = c_CMP_W'(i_abs_sum) << 1;
`else
      w_lhs = c_CMP_W'(i_abs_sum);
`endif
      w_thr = '0;
      o_mag = 3'd0;
      for (int k = 1; k <= SAO_OFF_MAX; k++) begin
`ifdef SAO_OFFSET_ROUND_EN
         w_thr = w_num * c_CMP_W'(2 * k - 1);
`else
         w_thr = w_num * c_CMP_W'(k);
`endif
         if ((i_num != '0) && (w_lhs >= w_thr)) begin
            o_mag = 3'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sao_deci_offset_est.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sao_deci_offset_est                                        |
// | Description : Per-category SAO offset estimation and distortion delta    |
// |               (num*off^2 - 2*off*sum), accumulated over groups of four   |
// |               categories. 4-stage pipeline, one category per cycle.      |
// | Config      : SAO_OFFSET_ROUND_EN selects rounded (defined) or truncated |
// |               (undefined) offset magnitude.                              |
// | Ports       : clk, arst (async, active-high)                             |
// |               valid_in/cnt_dc/num_blk_CTU/sum_blk_CTU  category input    |
// |               merge_off_L/U, merge_avail_L/U  neighbour merge offsets    |
// |               off_valid/off_out/off_cat       per-category offset (t+2)  |
// |               grp_valid/grp_idx/grp_dist/grp_off  group result (t+4)     |
// |               done                            group-7 result pulse       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sao_deci_offset_est
   import sao_deci_pkg::*;
#(
   parameter int NUM_PIX_CTU_LOG2 = 5,
   parameter int DIFF_CLIP_BIT    = 4,
   parameter int STATE_LEN        = 6,
   parameter int NUM_ACCU_LEN     = NUM_PIX_CTU_LOG2 * 2 - 1
)(
   input  logic                                    clk,
   input  logic                                    arst,
   input  logic                                    valid_in,
   input  logic [STATE_LEN-1:0]                    cnt_dc,
   input  logic [NUM_ACCU_LEN:0]                   num_blk_CTU,
   input  logic signed [NUM_ACCU_LEN+DIFF_CLIP_BIT:0] sum_blk_CTU,
   input  logic [4*OFF_LEN-1:0]                    merge_off_L,
   input  logic [4*OFF_LEN-1:0]                    merge_off_U,
   input  logic                                    merge_avail_L,
   input  logic                                    merge_avail_U,
   output logic                                    off_valid,
   output logic signed [OFF_LEN-1:0]               off_out,
   output logic [4:0]                              off_cat,
   output logic                                    grp_valid,
   output logic [2:0]                              grp_idx,
   output logic signed [DIST_LEN-1:0]              grp_dist,
   output logic [4*OFF_LEN-1:0]                    grp_off,
   output logic                                    done
);

   localparam int c_NUM_W = NUM_ACCU_LEN + 1;
   localparam int c_SUM_W = NUM_ACCU_LEN + DIFF_CLIP_BIT + 1;

   // ---------------- S1: capture ----------------
   logic                     w_take;
   logic [4*OFF_LEN-1:0]     w_moff_vec;
   logic [OFF_LEN-1:0]       w_moff;
   logic                     w_avail;

   logic                     r_s1_vld;
   logic [c_NUM_W-1:0]       r_s1_num;
   logic signed [c_SUM_W-1:0] r_s1_sum;
   logic [4:0]               r_s1_cat;
   logic [OFF_LEN-1:0]       r_s1_moff;
   logic                     r_s1_avail;

   assign w_take     = valid_in && (cnt_dc < STATE_LEN'(32));
   assign w_moff_vec = (cnt_dc[4:2] == GRP_MRG_U) ? merge_off_U : merge_off_L;

   always_comb begin
      w_moff = '0;
      case (cnt_dc[1:0])
         2'd0:    w_moff = w_moff_vec[0*OFF_LEN +: OFF_LEN];
         2'd1:    w_moff = w_moff_vec[1*OFF_LEN +: OFF_LEN];
         2'd2:    w_moff = w_moff_vec[2*OFF_LEN +: OFF_LEN];
         default: w_moff = w_moff_vec[3*OFF_LEN +: OFF_LEN];
      endcase
      // Non-merge groups always have a valid result.
      w_avail = 1'b1;
      if (cnt_dc[4:2] == GRP_MRG_L) w_avail = merge_avail_L;
      if (cnt_dc[4:2] == GRP_MRG_U) w_avail = merge_avail_U;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s1_vld   <= 1'b0;
         r_s1_num   <= '0;
         r_s1_sum   <= '0;
         r_s1_cat   <= '0;
         r_s1_moff  <= '0;
         r_s1_avail <= 1'b0;
      end else begin
         r_s1_vld <= w_take;
         if (w_take) begin
            r_s1_num   <= num_blk_CTU;
            r_s1_sum   <= sum_blk_CTU;
            r_s1_cat   <= cnt_dc[4:0];
            r_s1_moff  <= w_moff;
            r_s1_avail <= w_avail;
         end
      end
   end

   // ---------------- S2: offset ----------------
   logic [c_SUM_W-1:0]        w_abs_sum;
   logic [2:0]                w_mag;
   logic signed [OFF_LEN-1:0] w_off;

   logic [c_NUM_W-1:0]        r_s2_num;
   logic signed [c_SUM_W-1:0] r_s2_sum;
   logic                      r_s2_avail;

   // Negating the most negative sum wraps to the correct unsigned magnitude.
   assign w_abs_sum = r_s1_sum[c_SUM_W-1] ? c_SUM_W'(-r_s1_sum) : c_SUM_W'(r_s1_sum);

   sao_off_mag #(
      .NUM_W (c_NUM_W),
      .SUM_W (c_SUM_W)
   ) u_off_mag (
      .i_num     (r_s1_num),
      .i_abs_sum (w_abs_sum),
      .o_mag     (w_mag)
   );

   always_comb begin
      w_off = '0;
      if (r_s1_num == '0) begin
         w_off = '0;
      end else if (is_merge_grp(r_s1_cat[4:2])) begin
         w_off = r_s1_moff;
      end else if (r_s1_sum[c_SUM_W-1]) begin
         w_off = OFF_LEN'(0) - OFF_LEN'(w_mag);
      end else begin
         w_off = OFF_LEN'(w_mag);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         off_valid  <= 1'b0;
         off_out    <= '0;
         off_cat    <= '0;
         r_s2_num   <= '0;
         r_s2_sum   <= '0;
         r_s2_avail <= 1'b0;
      end else begin
         off_valid <= r_s1_vld;
         if (r_s1_vld) begin
            off_out    <= w_off;
            off_cat    <= r_s1_cat;
            r_s2_num   <= r_s1_num;
            r_s2_sum   <= r_s1_sum;
            r_s2_avail <= r_s1_avail;
         end
      end
   end

   // ---------------- S3: category distortion ----------------
   logic signed [DIST_LEN-1:0] w_num_x;
   logic signed [DIST_LEN-1:0] w_sum_x;
   logic signed [DIST_LEN-1:0] w_off_x;
   logic signed [DIST_LEN-1:0] w_cross;
   logic signed [DIST_LEN-1:0] w_dist;

   logic                       r_s3_vld;
   logic signed [DIST_LEN-1:0] r_s3_dist;
   logic [4:0]                 r_s3_cat;
   logic [OFF_LEN-1:0]         r_s3_off;
   logic                       r_s3_avail;

   assign w_num_x = $signed(DIST_LEN'(r_s2_num));
   assign w_sum_x = {{(DIST_LEN-c_SUM_W){r_s2_sum[c_SUM_W-1]}}, r_s2_sum};
   assign w_off_x = {{(DIST_LEN-OFF_LEN){off_out[OFF_LEN-1]}}, off_out};
   assign w_cross = w_off_x * w_sum_x;
   assign w_dist  = w_num_x * w_off_x * w_off_x - (w_cross + w_cross);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s3_vld   <= 1'b0;
         r_s3_dist  <= '0;
         r_s3_cat   <= '0;
         r_s3_off   <= '0;
         r_s3_avail <= 1'b0;
      end else begin
         r_s3_vld <= off_valid;
         if (off_valid) begin
            r_s3_dist  <= w_dist;
            r_s3_cat   <= off_cat;
            r_s3_off   <= off_out;
            r_s3_avail <= r_s2_avail;
         end
      end
   end

   // ---------------- S4: group accumulation ----------------
   // r_seen holds lanes 0..2; lane 3 only consumes the mask and clears it.
   logic [1:0]                 w_lane;
   logic [2:0]                 w_grp;
   logic                       w_grp_ok;

   logic signed [DIST_LEN-1:0] r_acc;
   logic [2:0]                 r_seen;
   logic [2:0]                 r_grp;
   logic [3*OFF_LEN-1:0]       r_goff;

   assign w_lane   = r_s3_cat[1:0];
   assign w_grp    = r_s3_cat[4:2];
   assign w_grp_ok = (r_grp == w_grp);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_acc     <= '0;
         r_seen    <= '0;
         r_grp     <= '0;
         r_goff    <= '0;
         grp_valid <= 1'b0;
         grp_idx   <= '0;
         grp_dist  <= '0;
         grp_off   <= '0;
         done      <= 1'b0;
      end else begin
         grp_valid <= 1'b0;
         done      <= 1'b0;
         if (r_s3_vld) begin
            case (w_lane)
               2'd0: begin
                  r_acc                      <= r_s3_dist;
                  r_seen                     <= 3'b001;
                  r_grp                      <= w_grp;
                  r_goff[0*OFF_LEN +: OFF_LEN] <= r_s3_off;
               end
               2'd1: begin
                  if (w_grp_ok && r_seen[0]) begin
                     r_acc                      <= r_acc + r_s3_dist;
                     r_seen[1]                  <= 1'b1;
                     r_goff[1*OFF_LEN +: OFF_LEN] <= r_s3_off;
                  end else begin
                     r_seen <= '0;
                  end
               end
               2'd2: begin
                  if (w_grp_ok && (&r_seen[1:0])) begin
                     r_acc                      <= r_acc + r_s3_dist;
                     r_seen[2]                  <= 1'b1;
                     r_goff[2*OFF_LEN +: OFF_LEN] <= r_s3_off;
                  end else begin
                     r_seen <= '0;
                  end
               end
               default: begin
                  // Lane 3 closes the group whether or not it was complete.
                  r_seen <= '0;
                  r_acc  <= '0;
                  if (w_grp_ok && (&r_seen)) begin
                     grp_valid <= 1'b1;
                     grp_idx   <= w_grp;
                     done      <= (w_grp == GRP_MRG_U);
                     if (r_s3_avail) begin
                        grp_dist <= r_acc + r_s3_dist;
                        grp_off  <= {r_s3_off, r_goff};
                     end else begin
                        grp_dist <= DIST_MAX;
                        grp_off  <= '0;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sao_deci_offset_est.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sao_deci_offset_est                                     |
// | Description : Self-checking bench for sao_deci_offset_est with a         |
// |               behavioural model and a per-cycle compare process.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sao_deci_offset_est;

   localparam int DEPTH    = 4096;
   localparam int WORST    = 1048575;

   logic               clk = 1'b0;
   logic               arst = 1'b1;
   logic               valid_in = 1'b0;
   logic [5:0]         cnt_dc = '0;
   logic [9:0]         num_blk_CTU = '0;
   logic signed [13:0] sum_blk_CTU = '0;
   logic [15:0]        merge_off_L = '0;
   logic [15:0]        merge_off_U = '0;
   logic               merge_avail_L = 1'b0;
   logic               merge_avail_U = 1'b0;
   logic               off_valid;
   logic signed [3:0]  off_out;
   logic [4:0]         off_cat;
   logic               grp_valid;
   logic [2:0]         grp_idx;
   logic signed [20:0] grp_dist;
   logic [15:0]        grp_off;
   logic               done;

   sao_deci_offset_est dut (
      .clk           (clk),
      .arst          (arst),
      .valid_in      (valid_in),
      .cnt_dc        (cnt_dc),
      .num_blk_CTU   (num_blk_CTU),
      .sum_blk_CTU   (sum_blk_CTU),
      .merge_off_L   (merge_off_L),
      .merge_off_U   (merge_off_U),
      .merge_avail_L (merge_avail_L),
      .merge_avail_U (merge_avail_U),
      .off_valid     (off_valid),
      .off_out       (off_out),
      .off_cat       (off_cat),
      .grp_valid     (grp_valid),
      .grp_idx       (grp_idx),
      .grp_dist      (grp_dist),
      .grp_off       (grp_off),
      .done          (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- expected outputs per cycle ----------------
   bit          exp_ov   [DEPTH];
   int          exp_off  [DEPTH];
   int          exp_cat  [DEPTH];
   bit          exp_gv   [DEPTH];
   int          exp_gidx [DEPTH];
   int          exp_gdist[DEPTH];
   logic [15:0] exp_goff [DEPTH];
   bit          exp_done [DEPTH];

   logic [15:0] cfg_ml = '0, cfg_mu = '0;
   bit          cfg_al = 1'b1, cfg_au = 1'b1;

   // Current group attempt: number of in-order lanes gathered so far.
   int          run_len = 0, run_g = 0, run_acc = 0;
   logic [15:0] run_goff = '0;

   function automatic int mag_of(int num, int sum);
      int a, m;
      a = (sum < 0) ? -sum : sum;
      if (num == 0) return 0;
`ifdef SAO_OFFSET_ROUND_EN
      m = (2 * a + num) / (2 * num);
`else
      m = a / num;
`endif
      return (m > 7) ? 7 : m;
   endfunction

   function automatic int lane_off(logic [15:0] v, int lane);
      logic signed [3:0] x;
      x = v[lane*4 +: 4];
      return int'(x);
   endfunction

   function automatic int off_of(int cat, int num, int sum, logic [15:0] ml, logic [15:0] mu);
      if (num == 0) return 0;
      if (cat / 4 == 6) return lane_off(ml, cat % 4);
      if (cat / 4 == 7) return lane_off(mu, cat % 4);
      return (sum < 0) ? -mag_of(num, sum) : mag_of(num, sum);
   endfunction

   function automatic int dist_of(int num, int off, int sum);
      return num * off * off - 2 * off * sum;
   endfunction

   task automatic model_take(int n, int cat, int num, int sum);
      int off, d, g, lane;
      bit av;
      g    = cat / 4;
      lane = cat % 4;
      off  = off_of(cat, num, sum, cfg_ml, cfg_mu);
      d    = dist_of(num, off, sum);
      exp_ov[n+2]  = 1'b1;
      exp_off[n+2] = off;
      exp_cat[n+2] = cat;
      if (lane == 0) begin
         run_len = 1; run_g = g; run_acc = d;
         run_goff = '0; run_goff[3:0] = 4'(off);
      end else if (run_len == lane && run_g == g) begin
         run_acc += d;
         run_goff[lane*4 +: 4] = 4'(off);
         run_len++;
         if (lane == 3) begin
            av = (g == 6) ? cfg_al : (g == 7) ? cfg_au : 1'b1;
            exp_gv[n+4]    = 1'b1;
            exp_gidx[n+4]  = g;
            exp_gdist[n+4] = av ? run_acc : WORST;
            exp_goff[n+4]  = av ? run_goff : 16'h0;
            exp_done[n+4]  = (g == 7);
         end
      end else begin
         run_len = 0;
      end
      if (lane == 3) run_len = 0;
   endtask

   task automatic flush(int n);
      for (int i = n; i < DEPTH; i++) begin
         exp_ov[i] = 0; exp_gv[i] = 0; exp_done[i] = 0;
      end
      run_len = 0;
   endtask

   task automatic drive(input bit v, input int cat, input int num, input int sum);
      @(posedge clk); #1;
      valid_in      = v;
      cnt_dc        = 6'(cat);
      num_blk_CTU   = 10'(num);
      sum_blk_CTU   = 14'(sum);
      merge_off_L   = cfg_ml;
      merge_off_U   = cfg_mu;
      merge_avail_L = cfg_al;
      merge_avail_U = cfg_au;
      if (v && cat < 32 && !arst) model_take(cyc, cat, num, sum);
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask

   // ---------------- compare process ----------------
   int          pl_cyc[$], pl_idx[$], pl_dist[$], pl_done[$];
   logic [15:0] pl_goff[$];

   task automatic clear_log();
      pl_cyc.delete(); pl_idx.delete(); pl_dist.delete();
      pl_done.delete(); pl_goff.delete();
   endtask

   always @(negedge clk) begin
      if (arst) begin
         chk("reset_zero", longint'({off_valid, off_out, off_cat, grp_valid,
                                     grp_idx, grp_dist, grp_off, done}), 0);
      end else begin
         chk("off_valid", off_valid, exp_ov[cyc]);
         if (exp_ov[cyc]) begin
            chk("off_out", off_out, exp_off[cyc]);
            chk("off_cat", off_cat, exp_cat[cyc]);
         end
         chk("grp_valid", grp_valid, exp_gv[cyc]);
         chk("done", done, exp_done[cyc]);
         if (exp_gv[cyc]) begin
            chk("grp_idx", grp_idx, exp_gidx[cyc]);
            chk("grp_dist", grp_dist, exp_gdist[cyc]);
            chk("grp_off", grp_off, exp_goff[cyc]);
         end
         if (grp_valid) begin
            pl_cyc.push_back(cyc); pl_idx.push_back(int'(grp_idx));
            pl_dist.push_back(int'(grp_dist)); pl_done.push_back(int'(done));
            pl_goff.push_back(grp_off);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n3, c, cat, num, sum;

      // Model pinned to hand-computed values.
`ifdef SAO_OFFSET_ROUND_EN
      chk("pin_off_10_27", off_of(0, 10, 27, 0, 0), 3);
      chk("pin_dist_10_27", dist_of(10, 3, 27), -72);
      chk("pin_off_4_m10", off_of(0, 4, -10, 0, 0), -3);
      chk("pin_dist_4_m10", dist_of(4, -3, -10), -24);
`else
      chk("pin_off_10_27", off_of(0, 10, 27, 0, 0), 2);
      chk("pin_dist_10_27", dist_of(10, 2, 27), -68);
      chk("pin_off_4_m10", off_of(0, 4, -10, 0, 0), -2);
      chk("pin_dist_4_m10", dist_of(4, -2, -10), -24);
`endif
      chk("pin_off_clip", off_of(0, 1, 100, 0, 0), 7);
      chk("pin_dist_clip", dist_of(1, 7, 100), -1351);
      chk("pin_off_num0", off_of(0, 0, 5, 0, 0), 0);

      repeat (3) @(posedge clk);
      #1 arst = 1'b0;

      // Directed group 0 from the worked examples.
      clear_log();
      drive(1, 0, 10, 27);
      drive(1, 1, 1, 100);
      drive(1, 2, 4, -10);
      drive(1, 3, 0, 5);
      idle(6);
      chk("dir_grp0_count", pl_idx.size(), 1);
`ifdef SAO_OFFSET_ROUND_EN
      if (pl_dist.size() > 0) chk("dir_grp0_dist", pl_dist[0], -1447);
`else
      if (pl_dist.size() > 0) chk("dir_grp0_dist", pl_dist[0], -1443);
`endif

      // Four empty categories: zero delta, four cycles after lane 3.
      clear_log();
      for (int i = 0; i < 4; i++) begin
         drive(1, i, 0, 5);
         if (i == 3) n3 = cyc;
      end
      idle(6);
      chk("num0_count", pl_idx.size(), 1);
      if (pl_idx.size() > 0) begin
         chk("num0_dist", pl_dist[0], 0);
         chk("num0_latency", pl_cyc[0], n3 + 4);
      end

      // Back-to-back full sweep.
      clear_log();
      for (int i = 0; i < 32; i++) drive(1, i, $urandom_range(0, 1023), $urandom_range(0, 16383) - 8192);
      idle(6);
      chk("sweep_count", pl_idx.size(), 8);
      for (int i = 0; i < pl_idx.size() && i < 8; i++) begin
         chk("sweep_idx", pl_idx[i], i);
         chk("sweep_done", pl_done[i], (i == 7) ? 1 : 0);
         if (i > 0) chk("sweep_spacing", pl_cyc[i] - pl_cyc[i-1], 4);
      end

      // Gap at cnt_dc=5 discards group 1 only.
      clear_log();
      for (int i = 0; i < 12; i++) drive(i != 5, i, $urandom_range(1, 200), $urandom_range(0, 2000) - 1000);
      idle(6);
      chk("gap_count", pl_idx.size(), 2);
      if (pl_idx.size() == 2) begin
         chk("gap_first", pl_idx[0], 0);
         chk("gap_second", pl_idx[1], 2);
      end

      // No up-merge candidate: worst cost, zero offsets.
      clear_log();
      cfg_mu = 16'h7A3C; cfg_au = 1'b0;
      for (int i = 28; i < 32; i++) drive(1, i, $urandom_range(1, 100), $urandom_range(0, 400) - 200);
      idle(6);
      cfg_au = 1'b1;
      chk("noavail_count", pl_idx.size(), 1);
      if (pl_idx.size() > 0) begin
         chk("noavail_dist", pl_dist[0], WORST);
         chk("noavail_goff", pl_goff[0], 0);
         chk("noavail_done", pl_done[0], 1);
      end

      // Left merge with offsets {1,0,0,-1}.
      clear_log();
      cfg_ml = 16'hF001; cfg_al = 1'b1;
      drive(1, 24, 2, 4);
      drive(1, 25, 2, 0);
      drive(1, 26, 2, 0);
      drive(1, 27, 2, -4);
      idle(6);
      chk("mergeL_count", pl_idx.size(), 1);
      if (pl_idx.size() > 0) begin
         chk("mergeL_dist", pl_dist[0], -12);
         chk("mergeL_goff", pl_goff[0], 16'hF001);
      end

      // Reset while cnt_dc=14 is presented.
      clear_log();
      for (int i = 0; i < 14; i++) drive(1, i, $urandom_range(0, 500), $urandom_range(0, 4000) - 2000);
      @(posedge clk); #1;
      arst = 1'b1; valid_in = 1'b1; cnt_dc = 6'd14;
      flush(cyc);
      @(posedge clk); #1;
      arst = 1'b0; valid_in = 1'b0;
      idle(8);
      chk("rst_count", pl_idx.size(), 2);
      if (pl_idx.size() == 2) chk("rst_last_idx", pl_idx[1], 1);

      // Randomized traffic with gaps, dropped indices and merge changes.
      c = 0;
      for (int i = 0; i < 400; i++) begin
         cfg_ml = 16'($urandom); cfg_mu = 16'($urandom);
         cfg_al = ($urandom_range(0, 3) != 0); cfg_au = ($urandom_range(0, 3) != 0);
         cat = ($urandom_range(0, 19) == 0) ? $urandom_range(32, 63) : c;
         num = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1023);
         sum = $urandom_range(0, 16383) - 8192;
         drive($urandom_range(0, 9) != 0, cat, num, sum);
         c = (c + 1) % 32;
      end
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
